// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-input round-robin arbiter: on a conflict the port not granted last wins.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_d,
  input  logic req_i,
  input  logic update,
  output logic grant,
  output logic last_grant
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    if (req_d && req_i) begin
      grant = ~last_grant_q;
    end else if (req_i) begin
      grant = PORT_I;
    end else begin
      grant = PORT_D;
    end
    last_grant_d = update ? grant : last_grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 16-bit async SRAM between the data and fetch ports; each 32-bit
// word is two half accesses (low then high), and every SRAM pin is registered.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(ACCESS_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             we_q, we_d;
  logic [16:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [15:0]      lo_buf_q, lo_buf_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic             d_ready_q, d_ready_d;
  logic             i_ready_q, i_ready_d;
  logic [17:0]      sram_addr_q, sram_addr_d;
  logic             ce_n_q, ce_n_d;
  logic             be_n_q, be_n_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic             dq_oe_q, dq_oe_d;
  logic [15:0]      dq_out_q, dq_out_d;

  logic grant, last_grant, arb_update, owner_d, active, half;
  logic unused_addr_bits;

  // last_grant doubles as the owner id for the transaction in flight.
  sram_rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst),
    .req_d      (d_req),
    .req_i      (i_req),
    .update     (arb_update),
    .grant      (grant),
    .last_grant (last_grant)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lo_buf_d   = lo_buf_q;
    d_rdata_d  = d_rdata_q;
    i_rdata_d  = i_rdata_q;
    arb_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          arb_update = 1'b1;
          we_d       = (grant == PORT_D) && d_we;
          addr_d     = (grant == PORT_I) ? i_addr[18:2] : d_addr[18:2];
          wdata_d    = d_wdata;
          phase_d    = '0;
          state_d    = LO;
        end
      end
      LO: begin
        if (phase_q == LAST_PHASE) begin
          if (!we_q) lo_buf_d = SRAM_DQ;
          phase_d = '0;
          state_d = HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      HI: begin
        if (phase_q == LAST_PHASE) begin
          // Commit both halves at once so rdata never shows a torn word.
          if (!we_q) begin
            if (last_grant == PORT_D) d_rdata_d = {SRAM_DQ, lo_buf_q};
            else                      i_rdata_d = {SRAM_DQ, lo_buf_q};
          end
          phase_d = '0;
          state_d = DONE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pins are decoded from the next state so the registers line up with state_q.
    owner_d     = arb_update ? grant : last_grant;
    active      = (state_d == LO) || (state_d == HI);
    half        = (state_d == HI);
    sram_addr_d = active ? {addr_d, half} : '0;
    ce_n_d      = ~active;
    be_n_d      = ~active;
    oe_n_d      = ~(active && !we_d);
    we_n_d      = ~(active && we_d && (phase_d != LAST_PHASE));
    dq_oe_d     = active && we_d;
    dq_out_d    = !active ? 16'h0000 : (half ? wdata_d[31:16] : wdata_d[15:0]);
    d_ready_d   = (state_d == DONE) && (owner_d == PORT_D);
    i_ready_d   = (state_d == DONE) && (owner_d == PORT_I);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_buf_q    <= '0;
      d_rdata_q   <= '0;
      i_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      i_ready_q   <= 1'b0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      be_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_buf_q    <= lo_buf_d;
      d_rdata_q   <= d_rdata_d;
      i_rdata_q   <= i_rdata_d;
      d_ready_q   <= d_ready_d;
      i_ready_q   <= i_ready_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      be_n_q      <= be_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_UB_N = be_n_q;
  assign SRAM_LB_N = be_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign i_ready   = i_ready_q;

  assign unused_addr_bits = ^{d_addr[31:19], d_addr[1:0], i_addr[31:19], i_addr[1:0]};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed scoreboard bench for sram_port_arbiter with an async SRAM model.
module tb_sram_port_arbiter;

  localparam int N  = 3;
  localparam int N2 = 2;

  typedef struct {
    logic [1:0]  rdy;
    logic [31:0] d_data;
    logic [31:0] i_data;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        d_req, d_we, i_req, d_ready, i_ready;
  logic [31:0] d_addr, d_wdata, d_rdata, i_addr, i_rdata;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;

  logic        d2_req, i2_req, d2_ready, i2_ready;
  logic [31:0] d2_rdata, i2_rdata;
  logic [31:0] d2_addr, i2_addr;
  wire  [15:0] sram2_dq;
  logic [17:0] sram2_addr;
  logic        ub2_n, lb2_n, we2_n, ce2_n, oe2_n;

  logic [15:0]  mem [0:255];
  logic [255:0] wr_vld;
  logic         mem_clr;
  wire          unused_tb = ^{sram_addr[17:8], sram2_addr[17:8], ub_n, lb_n, ub2_n, lb2_n, we2_n};

  function automatic logic [15:0] init_half(input logic [7:0] a);
    case (a)
      8'd8:    return 16'hBEEF;
      8'd9:    return 16'hDEAD;
      default: return {~a, a};
    endcase
  endfunction

  assign sram_dq = (!ce_n && !oe_n && we_n) ?
                   (wr_vld[sram_addr[7:0]] ? mem[sram_addr[7:0]] : init_half(sram_addr[7:0])) : 16'bz;

  always @(posedge clk) begin
    if (mem_clr) begin
      wr_vld <= '0;
    end else if (!ce_n && !we_n) begin
      mem[sram_addr[7:0]]    <= sram_dq;
      wr_vld[sram_addr[7:0]] <= 1'b1;
    end
  end

  assign sram2_dq = (!ce2_n && !oe2_n) ? init_half(sram2_addr[7:0]) : 16'bz;

  sram_port_arbiter #(.ACCESS_CYCLES(N)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  sram_port_arbiter #(.ACCESS_CYCLES(N2)) dut2 (
    .clk(clk), .rst(rst),
    .d_req(d2_req), .d_we(1'b0), .d_addr(d2_addr), .d_wdata(32'h0),
    .d_rdata(d2_rdata), .d_ready(d2_ready),
    .i_req(i2_req), .i_addr(i2_addr), .i_rdata(i2_rdata), .i_ready(i2_ready),
    .SRAM_DQ(sram2_dq), .SRAM_ADDR(sram2_addr), .SRAM_UB_N(ub2_n), .SRAM_LB_N(lb2_n),
    .SRAM_WE_N(we2_n), .SRAM_CE_N(ce2_n), .SRAM_OE_N(oe2_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] rdy, input logic [31:0] dd, input logic [31:0] id,
                      input int gap);
    sb.push_back('{rdy: rdy, d_data: dd, i_data: id, gap: gap});
  endtask

  // Waits for n ready pulses, popping the scoreboard at each; optionally
  // checks the pins cycle by cycle for the first transaction.
  task automatic run(input int n, input int d_cnt, input int i_cnt, input int since0,
                     input bit pins, input logic pin_we, input logic [31:0] pin_addr,
                     input logic [31:0] pin_wdata);
    int   since = since0;
    int   got   = 0;
    int   d_left = d_cnt;
    int   i_left = i_cnt;
    exp_t e;
    logic hf;
    int   ph;
    while (got < n && since < 100) begin
      @(posedge clk); #1;
      since++;
      if (pins && got == 0 && since <= 2*N) begin
        hf = (since > N);
        ph = (since - 1) % N;
        chk("sram_addr", 32'(sram_addr), 32'({pin_addr[18:2], hf}));
        chk("ctl_n", 32'({ce_n, ub_n, lb_n, oe_n, we_n}),
            32'({3'b000, pin_we, (pin_we ? (ph == N-1) : 1'b1)}));
        chk("dq_oe", 32'(dut.dq_oe_q), 32'(pin_we));
        if (pin_we) chk("dq_out", 32'(sram_dq), 32'(hf ? pin_wdata[31:16] : pin_wdata[15:0]));
      end
      if (d_ready || i_ready) begin
        $display("txn %0d: ready d=%0b i=%0b after %0d cycles d_rdata=%h i_rdata=%h",
                 total, d_ready, i_ready, since, d_rdata, i_rdata);
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'({d_ready, i_ready}), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("ready_port", 32'({d_ready, i_ready}), 32'(e.rdy));
          chk("ready_gap", since, e.gap);
          chk("d_rdata", d_rdata, e.d_data);
          chk("i_rdata", i_rdata, e.i_data);
        end
        chk("done_ctl_n", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1F);
        chk("done_dq_oe", 32'(dut.dq_oe_q), 32'h0);
        if (d_ready) begin d_left--; if (d_left <= 0) d_req = 1'b0; end
        if (i_ready) begin i_left--; if (i_left <= 0) i_req = 1'b0; end
        since = 0;
        got++;
      end
    end
    chk("ready_count", got, n);
    d_req = 1'b0;
    i_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] iw, ix;
    int since, got, drive_cnt;
    iw = {init_half(8'd33), init_half(8'd32)};
    ix = {init_half(8'd35), init_half(8'd34)};

    rst = 1'b0; mem_clr = 1'b1;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; i_req = 0; i_addr = 0;
    d2_req = 0; i2_req = 0; d2_addr = 32'h10; i2_addr = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl_n", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1F);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_oe", 32'(dut.dq_oe_q), 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_ready", 32'({d_ready, i_ready}), 32'h0);
    mem_clr = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // D read of word 4
    d_addr = 32'h10; d_we = 0;
    push(2'b10, 32'hDEADBEEF, 32'h0, 2*N+1);
    d_req = 1;
    run(1, 1, 0, 0, 1'b1, 1'b0, 32'h10, 32'h0);

    // D write then read-back; the write leaves d_rdata alone
    d_addr = 32'h20; d_we = 1; d_wdata = 32'h12345678;
    push(2'b10, 32'hDEADBEEF, 32'h0, 2*N+1);
    d_req = 1;
    run(1, 1, 0, 0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    d_we = 0; d_wdata = 0;
    push(2'b10, 32'h12345678, 32'h0, 2*N+1);
    d_req = 1;
    run(1, 1, 0, 0, 1'b1, 1'b0, 32'h20, 32'h0);

    // reset during the HI phase of a write
    d_addr = 32'h60; d_we = 1; d_wdata = 32'hAAAA5555;
    d_req = 1;
    repeat (N+2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ctl_n", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1F);
    chk("midrst_addr", 32'(sram_addr), 32'h0);
    chk("midrst_dq_oe", 32'(dut.dq_oe_q), 32'h0);
    chk("midrst_ready", 32'({d_ready, i_ready}), 32'h0);
    chk("midrst_d_rdata", d_rdata, 32'h0);
    d_req = 0; d_we = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("postrst_ready", 32'({d_ready, i_ready}), 32'h0);
      chk("postrst_ctl_n", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1F);
    end

    // simultaneous requests after reset: D, I, D
    d_addr = 32'h10; i_addr = 32'h40;
    push(2'b10, 32'hDEADBEEF, 32'h0, 2*N+1);
    push(2'b01, 32'hDEADBEEF, iw, 2*N+2);
    push(2'b10, 32'hDEADBEEF, iw, 2*N+2);
    d_req = 1; i_req = 1;
    run(3, 2, 1, 0, 1'b0, 1'b0, 32'h0, 32'h0);

    // I held, D arrives mid-transaction and is served next
    i_addr = 32'h44;
    push(2'b01, 32'hDEADBEEF, ix, 2*N+1);
    push(2'b10, 32'h12345678, ix, 2*N+2);
    push(2'b01, 32'h12345678, ix, 2*N+2);
    i_req = 1;
    repeat (3) begin @(posedge clk); #1; end
    d_addr = 32'h20; d_req = 1;
    run(3, 1, 2, 3, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("sb_drained", sb.size(), 0);

    // two-cycle build, continuous alternating reads
    d2_req = 1; i2_req = 1;
    since = 0; got = 0; drive_cnt = 0;
    while (got < 4 && since < 50) begin
      @(posedge clk); #1;
      since++;
      if (dut2.dq_oe_q) drive_cnt++;
      if (d2_ready || i2_ready) begin
        $display("txn %0d: n2 ready d=%0b i=%0b after %0d cycles", total, d2_ready, i2_ready, since);
        chk("n2_port", 32'({d2_ready, i2_ready}), (got % 2 == 0) ? 32'h2 : 32'h1);
        chk("n2_gap", since, (got == 0) ? 2*N2+1 : 2*N2+2);
        if (got % 2 == 0) chk("n2_d_rdata", d2_rdata, 32'hDEADBEEF);
        else              chk("n2_i_rdata", i2_rdata, iw);
        since = 0;
        got++;
      end
    end
    d2_req = 0; i2_req = 0;
    chk("n2_count", got, 4);
    chk("n2_dq_driven", drive_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single 16-bit off-chip SRAM between two 32-bit requesters: the MEM-stage data port (D) and the IF-stage instruction-fetch port (I).
- Arbitrates round-robin and sequences each 32-bit word as two 16-bit half accesses (low, then high).
- Drives the SRAM pins and returns a one-cycle ready pulse per completed transaction.
- The pipeline top derives its stage freezes from req & ~ready on each port.

Parameters:
- ACCESS_CYCLES, 3, clock cycles per 16-bit half access; legal range 2..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- d_req  in  1  data request; level, held until d_ready
- d_we  in  1  1 = write, 0 = read; sampled with d_req
- d_addr  in  32  byte address; bits [18:2] used, others ignored
- d_wdata  in  32  write data
- d_rdata  out  32  read data, registered
- d_ready  out  1  one-cycle completion pulse
- i_req  in  1  fetch request; read only
- i_addr  in  32  byte address; bits [18:2] used
- i_rdata  out  32  fetched instruction, registered
- i_ready  out  1  one-cycle completion pulse
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  out  18  {word_addr[16:0], half}
- SRAM_UB_N, SRAM_LB_N  out  1 each  byte enables
- SRAM_WE_N  out  1  write enable
- SRAM_CE_N  out  1  chip enable
- SRAM_OE_N  out  1  output enable

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - state=IDLE, all SRAM_*_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - d_rdata=0, i_rdata=0, both ready=0.
  - last_grant=I, so D wins the first conflict.
- Reset mid-transaction: the transaction is abandoned, no ready is issued, and SRAM writes may be partial. The requester re-issues after reset.
- States: IDLE, LO, HI, DONE. A phase counter counts 0..ACCESS_CYCLES-1 inside LO and HI.
- IDLE:
  - No request: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the port not in last_grant.
  - On grant: latch port id, we (forced 0 for I), addr[18:2] and wdata; update last_grant; go to LO.
- LO, cycles 0..N-1:
  - SRAM_ADDR={addr[18:2],1'b0}; CE_N=0, UB_N=0, LB_N=0.
  - Read: OE_N=0, WE_N=1, DQ=Z; capture DQ into rdata[15:0] of the owning port on cycle N-1.
  - Write: OE_N=1; DQ=wdata[15:0] for all N cycles; WE_N=0 on cycles 0..N-2 and 1 on cycle N-1 (data hold).
  - After cycle N-1, go to HI.
- HI: same as LO, with half bit=1, wdata[31:16] and rdata[31:16]. After cycle N-1, go to DONE.
- DONE:
  - SRAM idle (all _N=1, DQ=Z).
  - Owning port's ready=1 for exactly this cycle; rdata valid and stable from this cycle until that port's next read completes.
  - Next state is IDLE.
- Latency: ready rises 2*ACCESS_CYCLES+1 cycles after the IDLE grant cycle (7 cycles at the default).
- Throughput: one word per 2N+2 cycles.
- Requester rules:
  - Drop req on the cycle after ready; IDLE then samples it.
  - A req still high in IDLE is treated as a new transaction.
  - addr, we and wdata may change after the grant, since they are latched.
- Only the owning port's rdata changes. The other port's rdata holds its value across transactions.
- A write never updates d_rdata.
- SRAM_DQ is driven only in LO/HI of a write; there is no bus contention in IDLE or DONE.
- A request arriving during LO/HI/DONE waits. D can be starved by I only never, because of round-robin.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {IDLE, LO, HI, DONE};
  - port id constants PORT_D=1'b0, PORT_I=1'b1;
  - counter width localparam (4 bits).
- One sub-module, sram_rr_arb2: 2-input round-robin arbiter.
  - Inputs: req_d, req_i, an update strobe.
  - Outputs: grant and its last_grant register.
  - Reset: asynchronous active-low, last_grant=PORT_I.

Test Plan:
- D read, addr=0x0000_0010, SRAM model word 4 = 0xDEAD_BEEF (half addr 8=0xBEEF, 9=0xDEAD) -> SRAM_ADDR 8 for 3 cycles then 9 for 3 cycles, OE_N=0, WE_N=1; d_ready pulses 7 cycles after grant; d_rdata=0xDEADBEEF; i_rdata unchanged.
- D write, addr=0x0000_0020, wdata=0x1234_5678 -> DQ=0x5678 at SRAM_ADDR 16, then 0x1234 at 17; WE_N low 2 of 3 cycles per half; read-back returns 0x12345678.
- d_req and i_req rise in the same cycle after reset -> D granted first; I granted immediately after D's DONE/IDLE; no back-to-back D grant while i_req is held.
- I held continuously while D requests once mid-I-transaction -> D served next, without waiting for a second I transaction.
- rst pulled low during the HI phase of a write -> all SRAM_*_N=1 and DQ=Z in the same cycle, no ready pulse; after release the arbiter is in IDLE and a new D read completes normally.
- ACCESS_CYCLES=2 build, continuous alternating D/I reads -> ready every 6 cycles, alternating ports; DQ never driven during reads.
